// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side end of the bs_gnrtr_n_rbtr bus.
// A show-ahead TX FIFO feeds host packets to the bus (pndng/D_pop/pop).
// A show-ahead RX FIFO captures bus deliveries (push/D_push) that pass the
// destination filter, and the host drains it (rd_en/rd_data).
module bus_dev_endpoint #(
  parameter int       pckg_sz   = 16,
  parameter int       depth     = 8,
  parameter logic [7:0] id      = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter bit       rx_filter = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_empty,
  output logic [$clog2(depth):0]     rx_count,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic                       pop_err,
  output logic [7:0]                 rx_drops
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;

  logic       tx_do_pop, tx_do_wr;
  logic       rx_match, rx_accept, rx_reject, rx_do_rd, rx_do_wr;
  logic [7:0] rx_dest;

  // Decode which strobes actually take effect this cycle, from registered counts
  always_comb begin
    tx_do_pop = pop && (tx_count != '0);
    tx_do_wr  = wr_en && ((tx_count != full_cnt) || tx_do_pop);
    rx_dest   = D_push[pckg_sz-1 -: 8];
    rx_match  = !rx_filter || (rx_dest == id) || (rx_dest == broadcast);
    rx_accept = push && rx_match;
    rx_reject = push && !rx_match;
    rx_do_rd  = rd_en && (rx_count != '0);
    rx_do_wr  = rx_accept && ((rx_count != full_cnt) || rx_do_rd);
  end

  // Status and data outputs come only from registered counts, pointers and memory
  always_comb begin
    pndng    = (tx_count != '0);
    tx_full  = (tx_count == full_cnt);
    D_pop    = pndng ? tx_mem[tx_rp] : '0;
    rx_empty = (rx_count == '0);
    rd_data  = rx_empty ? '0 : rx_mem[rx_rp];
  end

  // Packet storage; contents are left unreset because outputs are masked when empty
  always_ff @(posedge clk) begin
    if (tx_do_wr && !reset) tx_mem[tx_wp] <= wr_data;
    if (rx_do_wr && !reset) rx_mem[rx_wp] <= D_push;
  end

  // TX pointers, occupancy and error flags; a full-FIFO write+pop reuses the slot just retired
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
      pop_err  <= 1'b0;
    end else begin
      if (tx_do_wr)  tx_wp <= tx_wp + 1'b1;
      if (tx_do_pop) tx_rp <= tx_rp + 1'b1;
      case ({tx_do_wr, tx_do_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (wr_en && !tx_do_wr)       tx_ovf  <= 1'b1;
      if (pop && (tx_count == '0))  pop_err <= 1'b1;
    end
  end

  // RX pointers, occupancy, overflow flag and saturating filtered-packet counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      rx_ovf   <= 1'b0;
      rx_drops <= 8'd0;
    end else begin
      if (rx_do_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_do_rd) rx_rp <= rx_rp + 1'b1;
      case ({rx_do_wr, rx_do_rd})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (rx_accept && !rx_do_wr) rx_ovf <= 1'b1;
      if (rx_reject && (rx_drops != 8'hFF)) rx_drops <= rx_drops + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed bench for bus_dev_endpoint with id=2, depth=4, 16-bit packets.
module tb_bus_dev_endpoint;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [2:0]  tx_count;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_empty;
  logic [2:0]  rx_count;
  logic        tx_ovf;
  logic        rx_ovf;
  logic        pop_err;
  logic [7:0]  rx_drops;

  int errors = 0;
  int checks = 0;

  bus_dev_endpoint #(
    .pckg_sz(16), .depth(4), .id(8'd2), .broadcast(8'hFF), .rx_filter(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .pop_err(pop_err), .rx_drops(rx_drops)
  );

  // Free-running 10 ns bus clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge, then settle 1 ns before touching anything
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of strobes, let the edge take them, then drop all strobes
  task automatic applyStimulus(input logic w, input logic [15:0] wd, input logic p,
                               input logic ps, input logic [15:0] dps, input logic r);
    wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dps; rd_en = r;
    tick();
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; wr_data = 0; pop = 0; push = 0; D_push = 0; rd_en = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_pndng", pndng, 0);
    checkOutput("rst_dpop", D_pop, 0);
    checkOutput("rst_txfull", tx_full, 0);
    checkOutput("rst_txcnt", tx_count, 0);
    checkOutput("rst_rxempty", rx_empty, 1);
    checkOutput("rst_rddata", rd_data, 0);
    checkOutput("rst_rxcnt", rx_count, 0);
    checkOutput("rst_flags", {tx_ovf, rx_ovf, pop_err}, 0);
    checkOutput("rst_drops", rx_drops, 0);

    // 1: basic TX write and pop ordering
    $display("[TB] step 1: TX order");
    applyStimulus(1, 16'h0311, 0, 0, 0, 0);
    checkOutput("t1_pndng", pndng, 1);
    checkOutput("t1_dpop_a", D_pop, 16'h0311);
    checkOutput("t1_cnt1", tx_count, 1);
    applyStimulus(1, 16'h0322, 0, 0, 0, 0);
    checkOutput("t1_cnt2", tx_count, 2);
    checkOutput("t1_dpop_head", D_pop, 16'h0311);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t1_dpop_b", D_pop, 16'h0322);
    checkOutput("t1_cnt3", tx_count, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t1_pndng_off", pndng, 0);
    checkOutput("t1_dpop_zero", D_pop, 0);

    // 2: TX overflow and write+pop while full
    $display("[TB] step 2: TX full");
    for (int i = 1; i <= 4; i++) applyStimulus(1, 16'h1000 + 16'(i), 0, 0, 0, 0);
    checkOutput("t2_full", tx_full, 1);
    checkOutput("t2_cnt4", tx_count, 4);
    checkOutput("t2_ovf_pre", tx_ovf, 0);
    applyStimulus(1, 16'h1005, 0, 0, 0, 0);
    checkOutput("t2_cnt_stay", tx_count, 4);
    checkOutput("t2_ovf", tx_ovf, 1);
    checkOutput("t2_head", D_pop, 16'h1001);
    applyStimulus(1, 16'h1006, 1, 0, 0, 0);
    checkOutput("t2_wp_cnt", tx_count, 4);
    checkOutput("t2_wp_head", D_pop, 16'h1002);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t2_d3", D_pop, 16'h1003);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t2_d4", D_pop, 16'h1004);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t2_d6", D_pop, 16'h1006);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t2_empty", pndng, 0);
    checkOutput("t2_poperr_none", pop_err, 0);

    // 3: RX address filtering
    $display("[TB] step 3: RX filter");
    applyStimulus(0, 0, 0, 1, 16'h02AA, 0);
    checkOutput("t3_rxempty", rx_empty, 0);
    checkOutput("t3_rd_a", rd_data, 16'h02AA);
    applyStimulus(0, 0, 0, 1, 16'hFFBB, 0);
    applyStimulus(0, 0, 0, 1, 16'h05CC, 0);
    checkOutput("t3_cnt", rx_count, 2);
    checkOutput("t3_drops", rx_drops, 1);
    applyStimulus(0, 0, 0, 0, 16'h05DD, 0);
    checkOutput("t3_nopush", rx_drops, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_rd_b", rd_data, 16'hFFBB);
    checkOutput("t3_cnt1", rx_count, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_drained", rx_empty, 1);
    checkOutput("t3_rd_zero", rd_data, 0);

    // 4: RX overflow and push+read while full
    $display("[TB] step 4: RX full");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 1, 16'h0210 + 16'(i), 0);
    checkOutput("t4_cnt4", rx_count, 4);
    applyStimulus(0, 0, 0, 1, 16'h0201, 0);
    checkOutput("t4_ovf", rx_ovf, 1);
    checkOutput("t4_cnt_stay", rx_count, 4);
    checkOutput("t4_head", rd_data, 16'h0211);
    applyStimulus(0, 0, 0, 1, 16'h0215, 1);
    checkOutput("t4_pr_cnt", rx_count, 4);
    checkOutput("t4_pr_head", rd_data, 16'h0212);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_r3", rd_data, 16'h0213);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_r4", rd_data, 16'h0214);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_r5", rd_data, 16'h0215);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_rd_empty_cnt", rx_count, 0);
    checkOutput("t4_rd_empty_flag", rx_empty, 1);

    // 5: pop on empty TX, then write+pop on empty after a reset
    $display("[TB] step 5: pop errors");
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t5_poperr", pop_err, 1);
    checkOutput("t5_cnt0", tx_count, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("t5_rst_poperr", pop_err, 0);
    applyStimulus(1, 16'h0777, 1, 0, 0, 0);
    checkOutput("t5_wp_cnt", tx_count, 1);
    checkOutput("t5_wp_head", D_pop, 16'h0777);
    checkOutput("t5_wp_poperr", pop_err, 1);

    // Drop counter saturates at 255
    for (int i = 0; i < 260; i++) applyStimulus(0, 0, 0, 1, 16'h0900, 0);
    checkOutput("t5_drops_sat", rx_drops, 255);

    // 6: reset mid-operation with every strobe asserted
    $display("[TB] step 6: reset flush");
    applyStimulus(1, 16'h0A01, 0, 1, 16'hFF01, 0);
    applyStimulus(1, 16'h0A02, 0, 1, 16'h0202, 0);
    applyStimulus(0, 0, 0, 1, 16'h0203, 0);
    checkOutput("t6_pre_tx", tx_count, 3);
    checkOutput("t6_pre_rx", rx_count, 3);
    reset = 1'b1;
    applyStimulus(1, 16'h0A03, 1, 1, 16'h0204, 1);
    reset = 1'b0;
    checkOutput("t6_txcnt", tx_count, 0);
    checkOutput("t6_rxcnt", rx_count, 0);
    checkOutput("t6_pndng", pndng, 0);
    checkOutput("t6_rxempty", rx_empty, 1);
    checkOutput("t6_flags", {tx_ovf, rx_ovf, pop_err}, 0);
    checkOutput("t6_drops", rx_drops, 0);
    checkOutput("t6_dpop", D_pop, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
